half_duplex_tx: RTL and testbench
=================================

// Module: half_duplex_tx
// PURPOSE
//  Frame serializer that sits directly upstream of the single-bit tristate bus driver.
//  - Accepts a parallel word over a valid/ready handshake.
//  - Produces the driver's data input (bus_d) and output enable (bus_oe).
//  - Releases the line (bus_oe=0) for a guard gap after each frame, so the far end can turn the bus around.
// PARAMETERS
//  DATA_W     8  payload bits per frame, sent LSB first; >=1
//  BIT_CYC    4  clk cycles per bit; >=1
//  GUARD_CYC  2  clk cycles the line stays released after the stop bit; >=1
// PORTS
//  clk       in   1       single clock; all logic on rising edge
//  rst       in   1       synchronous, active-high reset
//  tx_valid  in   1       tx_data holds a word to send
//  tx_data   in   DATA_W  payload; sampled only on the accept edge
//  tx_ready  out  1       block is idle and can accept a word
//  bus_d     out  1       data to the tristate driver's data input
//  bus_oe    out  1       enable to the tristate driver's enable input; 1 = drive line
//  busy      out  1       frame or guard gap in progress
//  done      out  1       one-cycle pulse when a frame completes
// BEHAVIOUR
//  Reset: at the first rising clk edge with rst=1, state=IDLE, bus_oe=0, bus_d=1, done=0, busy=0.
//  - tx_ready=1 in IDLE, whether rst is asserted or released.
//  Handshake: accept on an edge where tx_valid&&tx_ready; tx_data is latched into the shift register.
//  - tx_valid while tx_ready=0 is ignored; no queueing.
//  - tx_data changes after accept have no effect on the frame.
//  FSM, every bit held exactly BIT_CYC cycles, all outputs registered:
//    IDLE   bus_oe=0, bus_d=1; goes to START on accept
//    START  bus_oe=1, bus_d=0, one bit
//    DATA   bus_oe=1, bus_d=shift[0], DATA_W bits, LSB first
//    PARITY bus_oe=1, bus_d=even parity (^payload), one bit; exists only with HDX_PARITY_EN
//    STOP   bus_oe=1, bus_d=1, one bit
//    GUARD  bus_oe=0, bus_d=1, GUARD_CYC cycles; then IDLE
//  Timing, with the accept edge ending cycle 0:
//  - bus_oe high on cycles 1..N*BIT_CYC, where N = DATA_W+2, or DATA_W+3 with parity.
//  - Guard gap follows; IDLE, tx_ready=1 and done=1 are all on cycle N*BIT_CYC+GUARD_CYC+1.
//  - Defaults: oe cycles 1..40, guard 41..42, done/ready on cycle 43.
//  busy=1 for every non-IDLE cycle. done is high for exactly one cycle and never high while busy.
//  Back-to-back: if tx_valid is high in the done cycle, the next START begins on the following cycle.
//  - The line is therefore released for exactly GUARD_CYC+1 cycles between frames.
//  Reset mid-frame: on the next edge bus_oe=0 and the FSM returns to IDLE.
//  - The partial frame is dropped and no done pulse is produced.
//  Counters: bit-cycle counter is $clog2(BIT_CYC)+1 bits; bit index is $clog2(DATA_W)+1 bits.
//  - Neither counter ever wraps mid-state.
//  bus_oe never glitches: it changes only on clk edges, at START entry and at GUARD entry.
// CONFIGURATION
//  Macro HDX_PARITY_EN
//  - Defined: PARITY state is inserted between DATA and STOP; frame length is (DATA_W+3)*BIT_CYC.
//  - Undefined: no PARITY state and no parity logic; frame length is (DATA_W+2)*BIT_CYC.
// STRUCTURE
//  Package hdx_pkg holds:
//  - the state enum (IDLE, START, DATA, PARITY, STOP, GUARD)
//  - constant FRAME_BITS, derived from DATA_W and HDX_PARITY_EN
//  - function even_parity()
//  One sub-module: hdx_bit_timer.
//  - Cycle counter giving a one-cycle 'bit_end' tick every BIT_CYC cycles.
//  - Restarted by the FSM on each state entry; also reused to count the GUARD_CYC cycles.
// TESTING
//  1 Reset: hold rst 3 cycles -> bus_oe=0, bus_d=1, tx_ready=1, busy=0, done=0.
//  2 Default params, send 0xA5 -> bus_oe=1 on cycles 1..40.
//    - bus_d per 4-cycle bit: 0 | 1,0,1,0,0,1,0,1 | 1.
//    - bus_oe=0 on cycles 41..42; done=1 on cycle 43 only.
//  3 tx_valid held high with 0x3C then 0xC3 -> second accept on the cycle-43 edge; second START on cycle 44.
//  4 During the 0xA5 frame, pulse tx_valid with 0xFF at cycle 10 -> ignored; serialized bits still 0xA5.
//  5 rst=1 at cycle 12 of a frame -> bus_oe=0 from the next cycle, no done, tx_ready=1.
//    - A new word is then accepted normally.
//  6 HDX_PARITY_EN defined:
//    - Send 0x07 -> parity bit 1 on cycles 37..40, stop on 41..44, done on cycle 47.
//    - Send 0xA5 -> parity bit 0.

Source files
------------

// File: rtl/hdx_pkg.sv
// Shared types, constants and helpers for the half-duplex serializer.
// HDX_PARITY_EN adds an even-parity bit between the payload and the stop bit.
package hdx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        GUARD  = 3'd5
    } hdx_state_e;

    localparam int HDX_DATA_W = 8;
    // Widest payload the parity helper can fold.
    localparam int HDX_MAX_W  = 64;

`ifdef HDX_PARITY_EN
    localparam int HDX_OVERHEAD_BITS = 3;
`else
    localparam int HDX_OVERHEAD_BITS = 2;
`endif

    function automatic int frame_bits(input int data_w);
        return data_w + HDX_OVERHEAD_BITS;
    endfunction

    localparam int FRAME_BITS = frame_bits(HDX_DATA_W);

    function automatic logic even_parity(input logic [HDX_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/hdx_bit_timer.sv
// Free-running cycle counter: bit_end_o pulses on the last cycle of every len_i-cycle period.
// restart_i zeroes the count so a period always aligns with the FSM's state entry.
module hdx_bit_timer #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restart_i,
    input  logic [CNT_W-1:0] len_i,
    output logic             bit_end_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign bit_end_o = (cnt_q == (len_i - CNT_W'(1)));

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (restart_i || bit_end_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/half_duplex_tx.sv
// Frame serializer feeding a single-bit tristate driver: start, LSB-first payload, stop, then a released guard gap.
// Optional even-parity bit enabled by defining HDX_PARITY_EN.
module half_duplex_tx
    import hdx_pkg::*;
#(
    parameter int DATA_W    = HDX_DATA_W,
    parameter int BIT_CYC   = 4,
    parameter int GUARD_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              bus_d,
    output logic              bus_oe,
    output logic              busy,
    output logic              done
);

    localparam int CNT_MAX = (BIT_CYC > GUARD_CYC) ? BIT_CYC : GUARD_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int IDX_W   = $clog2(DATA_W) + 1;

    hdx_state_e        state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              bus_oe_q, bus_oe_d;
    logic              bus_d_q, bus_d_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              bit_end;
    logic              restart;
    logic [CNT_W-1:0]  period;

`ifdef HDX_PARITY_EN
    logic                 par_q, par_d;
    logic [HDX_MAX_W-1:0] par_in;

    always_comb begin
        par_in             = '0;
        par_in[DATA_W-1:0] = tx_data;
    end
`endif

    // The timer is shared: bit periods while driving, guard length while released.
    assign period  = (state_q == GUARD) ? CNT_W'(GUARD_CYC) : CNT_W'(BIT_CYC);
    assign restart = (state_d != state_q);

    hdx_bit_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .restart_i (restart),
        .len_i     (period),
        .bit_end_o (bit_end)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
`ifdef HDX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    state_d = START;
                    shift_d = tx_data;
                    idx_d   = '0;
`ifdef HDX_PARITY_EN
                    par_d   = even_parity(par_in);
`endif
                end
            end
            START: begin
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(DATA_W - 1)) begin
`ifdef HDX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef HDX_PARITY_EN
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
`endif
            STOP: begin
                if (bit_end) state_d = GUARD;
            end
            GUARD: begin
                if (bit_end) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they land in registers on the same edge.
        busy_d   = (state_d != IDLE);
        bus_oe_d = (state_d != IDLE) && (state_d != GUARD);
        bus_d_d  = 1'b1;
        case (state_d)
            START:   bus_d_d = 1'b0;
            DATA:    bus_d_d = shift_d[0];
`ifdef HDX_PARITY_EN
            PARITY:  bus_d_d = par_d;
`endif
            default: bus_d_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            idx_q    <= '0;
            bus_oe_q <= 1'b0;
            bus_d_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef HDX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            bus_oe_q <= bus_oe_d;
            bus_d_q  <= bus_d_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef HDX_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

    assign tx_ready = ~busy_q;
    assign bus_oe   = bus_oe_q;
    assign bus_d    = bus_d_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_half_duplex_tx.sv
// Scoreboard bench for half_duplex_tx: a frame-level model queues expected per-cycle traces, a monitor compares them.
module tb_half_duplex_tx;

    localparam int DW = 8;
    localparam int BC = 4;
    localparam int GC = 2;
`ifdef HDX_PARITY_EN
    localparam int NBITS = DW + 3;
`else
    localparam int NBITS = DW + 2;
`endif
    localparam int NB = NBITS * BC;
    localparam int L  = NB + GC + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tx_valid = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic          tx_ready, bus_d, bus_oe, busy, done;

    half_duplex_tx #(
        .DATA_W    (DW),
        .BIT_CYC   (BC),
        .GUARD_CYC (GC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .bus_d    (bus_d),
        .bus_oe   (bus_oe),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] oe;
        logic [127:0] d;
        logic [127:0] dn;
        logic [127:0] bsy;
        logic [127:0] rdy;
        int           start;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   m_rem = 0;
    bit   cap = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Expected line behaviour of one whole frame, from cycle 1 through the done cycle.
    function automatic exp_t build(input logic [DW-1:0] w, input int st);
        exp_t             e;
        logic [NBITS-1:0] bits;
        int               k;
        e.oe  = '0;
        e.d   = '0;
        e.dn  = '0;
        e.bsy = '0;
        e.rdy = '0;
        e.start = st;
        bits[0] = 1'b0;
        for (int i = 0; i < DW; i++) bits[1+i] = w[i];
`ifdef HDX_PARITY_EN
        bits[DW+1] = ^w;
`endif
        bits[NBITS-1] = 1'b1;
        k = 0;
        for (int n = 0; n < NBITS; n++) begin
            for (int c = 0; c < BC; c++) begin
                e.oe[k] = 1'b1; e.d[k] = bits[n]; e.bsy[k] = 1'b1;
                k++;
            end
        end
        for (int g = 0; g < GC; g++) begin
            e.d[k] = 1'b1; e.bsy[k] = 1'b1;
            k++;
        end
        e.d[k] = 1'b1; e.dn[k] = 1'b1; e.rdy[k] = 1'b1;
        return e;
    endfunction

    // Reference model: idle whenever no frame time remains; an accepted word occupies NB+GC cycles.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_rem = 0;
            end else if (m_rem != 0) begin
                m_rem = m_rem - 1;
            end else if (tx_valid) begin
                q.push_back(build(tx_data, cyc + 1));
                m_rem = NB + GC;
            end
            cyc = cyc + 1;
        end
    end

    // Monitor: a frame begins when busy rises; record L cycles and compare against the queued trace.
    initial begin
        exp_t         cur;
        logic [127:0] a_oe, a_d, a_dn, a_bsy, a_rdy;
        int           idx;
        logic         pb;
        pb  = 1'b0;
        idx = 0;
        a_oe = '0; a_d = '0; a_dn = '0; a_bsy = '0; a_rdy = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                cap = 0;
                pb  = 1'b0;
            end else begin
                if (!cap && busy === 1'b1 && !pb) begin
                    if (q.size() == 0) begin
                        chk("unexpected_frame", 128'(cyc), 128'(0));
                    end else begin
                        cur  = q.pop_front();
                        cap  = 1;
                        idx  = 0;
                        a_oe = '0; a_d = '0; a_dn = '0; a_bsy = '0; a_rdy = '0;
                        chk("start_cycle", 128'(cyc), 128'(cur.start));
                    end
                end
                if (cap) begin
                    a_oe[idx]  = bus_oe;
                    a_d[idx]   = bus_d;
                    a_dn[idx]  = done;
                    a_bsy[idx] = busy;
                    a_rdy[idx] = tx_ready;
                    idx++;
                    if (idx == L) begin
                        chk("bus_oe_trace", a_oe, cur.oe);
                        chk("bus_d_trace", a_d, cur.d);
                        chk("done_trace", a_dn, cur.dn);
                        chk("busy_trace", a_bsy, cur.bsy);
                        chk("tx_ready_trace", a_rdy, cur.rdy);
                        cap = 0;
                    end
                end
                pb = busy;
            end
        end
    end

    task automatic send(input logic [DW-1:0] w);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = w;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = DW'($urandom);
    endtask

    initial begin
        int n_done;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_bus_oe", 128'(bus_oe), 128'(0));
        chk("rst_bus_d", 128'(bus_d), 128'(1));
        chk("rst_tx_ready", 128'(tx_ready), 128'(1));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        send(8'hA5);
        repeat (L + 3) @(negedge clk);

        // Valid held across the whole frame: second word goes out straight after the done cycle.
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'h3C;
        @(negedge clk);
        tx_data  = 8'hC3;
        repeat (L) @(negedge clk);
        tx_valid = 1'b0;
        repeat (L + 5) @(negedge clk);

        send(8'hA5);
        repeat (9) @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (L + 3) @(negedge clk);

        send(8'h5A);
        repeat (11) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_bus_oe", 128'(bus_oe), 128'(0));
        chk("abort_tx_ready", 128'(tx_ready), 128'(1));
        chk("abort_busy", 128'(busy), 128'(0));
        rst = 1'b0;
        n_done = 0;
        repeat (L + 5) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
        end
        chk("abort_no_done", 128'(n_done), 128'(0));
        send(8'h81);
        repeat (L + 3) @(negedge clk);

        send(8'h07);
        repeat (L + 3) @(negedge clk);
        send(8'hA5);
        repeat (L + 3) @(negedge clk);

        repeat (1500) begin
            @(negedge clk);
            tx_valid = ($urandom_range(0, 3) == 0);
            tx_data  = DW'($urandom);
        end
        tx_valid = 1'b0;
        repeat (L + 10) @(negedge clk);
        chk("drain_queue", 128'(q.size()), 128'(0));
        chk("drain_capture", 128'(cap), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
